// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: decodes framed RX byte commands, drives the register
// file and the ALU, and returns read data / ALU results to the TX FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a command byte, other bytes ignored
// WR_ADDR  | register write: waiting for the address byte
// WR_DATA  | register write: waiting for the data byte
// RD_ADDR  | register read: waiting for the address byte
// RD_WAIT  | register read: waiting for read data from the reg file
// OP_A     | ALU with operands: waiting for operand A (goes to addr 0)
// OP_B     | ALU with operands: waiting for operand B (goes to addr 1)
// FUN      | waiting for the ALU function byte
// ALU_WAIT | ALU running, clock gate open, waiting for the result
// TX_LO    | sending result LSB, held while the TX FIFO is full
// TX_HI    | sending result MSB, held while the TX FIFO is full
// TX_RD    | sending register read data, held while the TX FIFO is full
module alu_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
   input  logic                      RF_RD_DATA_VLD,
   input  logic                      FIFO_FULL,
   output logic                      ALU_EN,
   output logic [3:0]                ALU_FUN,
   output logic                      CLK_GATE_EN,
   output logic [ADDR_WIDTH-1:0]     RF_ADDR,
   output logic                      RF_WR_EN,
   output logic                      RF_RD_EN,
   output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A  = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B  = ADDR_WIDTH'(1);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
      FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD
   } state_t;

   state_t state, state_nxt;

   logic [2*DATA_WIDTH-1:0] alu_hold;
   logic [DATA_WIDTH-1:0]   rd_hold;

   logic                    rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, clk_gate_en_nxt;
   logic [ADDR_WIDTH-1:0]   rf_addr_nxt;
   logic [DATA_WIDTH-1:0]   rf_wr_data_nxt;
   logic [3:0]              alu_fun_nxt;

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // next-state decode; every byte-consuming state advances only on RX_D_VLD
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if      (RX_P_DATA == CMD_WR)     state_nxt = WR_ADDR;
               else if (RX_P_DATA == CMD_RD)     state_nxt = RD_ADDR;
               else if (RX_P_DATA == CMD_ALU_OP) state_nxt = OP_A;
               else if (RX_P_DATA == CMD_ALU_NO) state_nxt = FUN;
            end
         end
         WR_ADDR:  if (RX_D_VLD)       state_nxt = WR_DATA;
         WR_DATA:  if (RX_D_VLD)       state_nxt = IDLE;
         RD_ADDR:  if (RX_D_VLD)       state_nxt = RD_WAIT;
         RD_WAIT:  if (RF_RD_DATA_VLD) state_nxt = TX_RD;
         OP_A:     if (RX_D_VLD)       state_nxt = OP_B;
         OP_B:     if (RX_D_VLD)       state_nxt = FUN;
         FUN:      if (RX_D_VLD)       state_nxt = ALU_WAIT;
         ALU_WAIT: if (ALU_OUT_VLD)    state_nxt = TX_LO;
         TX_LO:    if (!FIFO_FULL)     state_nxt = TX_HI;
         TX_HI:    if (!FIFO_FULL)     state_nxt = IDLE;
         TX_RD:    if (!FIFO_FULL)     state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // output decode: next values for the registered strobes, direct TX drive
   always_comb begin
      rf_addr_nxt     = RF_ADDR;
      rf_wr_data_nxt  = RF_WR_DATA;
      alu_fun_nxt     = ALU_FUN;
      clk_gate_en_nxt = CLK_GATE_EN;
      rf_wr_en_nxt    = 1'b0;
      rf_rd_en_nxt    = 1'b0;
      alu_en_nxt      = 1'b0;
      TX_P_DATA       = '0;
      TX_D_VLD        = 1'b0;
      case (state)
         WR_ADDR: if (RX_D_VLD) rf_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
         WR_DATA: begin
            if (RX_D_VLD) begin
               rf_wr_data_nxt = RX_P_DATA;
               rf_wr_en_nxt   = 1'b1;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               rf_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
               rf_rd_en_nxt = 1'b1;
            end
         end
         OP_A, OP_B: begin
            if (RX_D_VLD) begin
               rf_addr_nxt    = (state == OP_A) ? ADDR_OP_A : ADDR_OP_B;
               rf_wr_data_nxt = RX_P_DATA;
               rf_wr_en_nxt   = 1'b1;
            end
         end
         FUN: begin
            if (RX_D_VLD) begin
               alu_fun_nxt     = RX_P_DATA[3:0];
               alu_en_nxt      = 1'b1;
               clk_gate_en_nxt = 1'b1;
            end
         end
         ALU_WAIT: if (ALU_OUT_VLD) clk_gate_en_nxt = 1'b0;
         TX_LO: begin
            TX_P_DATA = alu_hold[DATA_WIDTH-1:0];
            TX_D_VLD  = !FIFO_FULL;
         end
         TX_HI: begin
            TX_P_DATA = alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
            TX_D_VLD  = !FIFO_FULL;
         end
         TX_RD: begin
            TX_P_DATA = rd_hold;
            TX_D_VLD  = !FIFO_FULL;
         end
         default: ;
      endcase
   end

   // registered outputs, so strobes land in the cycle after the accepting byte
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RF_ADDR     <= '0;
         RF_WR_DATA  <= '0;
         RF_WR_EN    <= 1'b0;
         RF_RD_EN    <= 1'b0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_GATE_EN <= 1'b0;
      end else begin
         RF_ADDR     <= rf_addr_nxt;
         RF_WR_DATA  <= rf_wr_data_nxt;
         RF_WR_EN    <= rf_wr_en_nxt;
         RF_RD_EN    <= rf_rd_en_nxt;
         ALU_EN      <= alu_en_nxt;
         ALU_FUN     <= alu_fun_nxt;
         CLK_GATE_EN <= clk_gate_en_nxt;
      end
   end

   // result holding registers; they keep their data through TX back-pressure
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         alu_hold <= '0;
         rd_hold  <= '0;
      end else begin
         if (state == ALU_WAIT && ALU_OUT_VLD)   alu_hold <= ALU_OUT;
         if (state == RD_WAIT && RF_RD_DATA_VLD) rd_hold  <= RF_RD_DATA;
      end
   end

endmodule
